// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the parity
// rule that the receiver and transmitter must compute identically.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // odd = 0 gives even parity (bit equals XOR of data), odd = 1 inverts it.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs; the reset value
// is configurable so an idle-high line does not look like an edge out of reset.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop. Each completed
// frame produces a one-cycle rx_valid with the byte and its error flags.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | waiting for a falling edge on the synchronized line
//   ST_START  | timing half a bit to confirm the start bit at its middle
//   ST_DATA   | sampling 8 data bits at bit centres, LSB first
//   ST_PARITY | sampling the parity bit
//   ST_STOP   | sampling the stop bit, then publishing the frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 6000000,
    parameter int BAUD_RATE = 9600,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic             ODD_PAR  = (PARITY != 0);

    logic                 rx_s;
    logic                 rx_prev_q;
    logic [2:0]           state_q,      state_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [2:0]           idx_q,        idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 par_q,        par_d;
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q,  frame_err_d;

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (rx),
        .sync_o  (rx_s)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_d        = par_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Edge-triggered so a line stuck low cannot restart reception.
                if (rx_prev_q && !rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Returning to IDLE at the stop midpoint leaves half a bit to
                // catch a back-to-back start edge.
                if (cnt_q == CNT_FULL) begin
                    cnt_d        = '0;
                    rx_data_d    = shift_q;
                    parity_err_d = (par_q != parity_bit(shift_q, ODD_PAR));
                    frame_err_d  = ~rx_s;
                    rx_valid_d   = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_prev_q    <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_prev_q    <= rx_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an even-parity and an odd-parity receiver share
// one serial line; expected frames are queued when sent and popped on rx_valid.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CF   = 480000;
    localparam int BR   = 9600;
    localparam int CPB  = CF / BR;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 3 + HALF + 10 * CPB;

    typedef struct {
        logic [7:0] d;
        logic       perr_even;
        logic       perr_odd;
        logic       ferr;
        int         start;
        logic       b2b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data,  rx_data_odd;
    logic       rx_valid, rx_valid_odd;
    logic       parity_err, parity_err_odd;
    logic       frame_err,  frame_err_odd;
    logic       rx_busy,    rx_busy_odd;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   last_valid = 0;
    logic busy_prev = 1'b0;

    uart_rx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(0)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .rx_busy(rx_busy)
    );

    uart_rx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(1)) dut_odd (
        .clk(clk), .reset_n(reset_n), .rx(rx),
        .rx_data(rx_data_odd), .rx_valid(rx_valid_odd), .parity_err(parity_err_odd),
        .frame_err(frame_err_odd), .rx_busy(rx_busy_odd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input logic b2b);
        exp_t e;
        e.d         = d;
        e.perr_even = (par != ^d);
        e.perr_odd  = (par != ~^d);
        e.ferr      = ~stp;
        e.start     = cyc;
        e.b2b       = b2b;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stp);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    always @(negedge clk) begin
        if (rx_valid || rx_valid_odd) begin
            check("valid_expected", (sb.size() != 0), 1);
            check("valid_even", rx_valid, 1);
            check("valid_odd", rx_valid_odd, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rx_data", rx_data, e.d);
                check("parity_err", parity_err, e.perr_even);
                check("frame_err", frame_err, e.ferr);
                check("rx_data_odd", rx_data_odd, e.d);
                check("parity_err_odd", parity_err_odd, e.perr_odd);
                check("latency", cyc - e.start, LAT);
                check("busy_low_on_valid", rx_busy, 0);
                check("busy_high_before_valid", busy_prev, 1);
                if (e.b2b) check("b2b_spacing", cyc - last_valid, FRAME_BITS * CPB);
            end
            last_valid = cyc;
            n_valid++;
        end
        busy_prev = rx_busy;
    end

    initial begin
        int v0;
        #23;
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", rx_busy, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // good frame, then even-parity error (odd receiver sees it as good)
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        idle_bits(2);
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        idle_bits(2);

        // framing error with the line held low afterwards
        v0 = n_valid;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (3) drive_bit(1'b0);
        check("ferr_single_strobe", n_valid - v0, 1);
        idle_bits(2);
        check("ferr_no_retrigger", n_valid - v0, 1);

        // false start shorter than half a bit
        v0 = n_valid;
        rx = 1'b0;
        repeat (HALF / 3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("false_start_busy", rx_busy, 1);
        repeat (HALF) @(posedge clk);
        #1;
        check("false_start_idle", rx_busy, 0);
        idle_bits(2);
        check("false_start_no_valid", n_valid - v0, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        idle_bits(2);

        // back-to-back frames with no idle gap
        send_frame(8'h00, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1);
        idle_bits(2);

        // reset during data bit 4 discards the frame
        v0 = n_valid;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rx = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        #1;
        check("pre_rst_busy", rx_busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_data", rx_data, 0);
        check("midrst_valid", rx_valid, 0);
        check("midrst_perr", parity_err, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_busy", rx_busy, 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_bits(2);
        check("midrst_no_valid", n_valid - v0, 0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        idle_bits(2);

        for (int i = 0; i < 4 * FRAME_BITS * CPB && sb.size() != 0; i++) @(posedge clk);
        check("drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
